// File: rtl/aq_ifu_btb_upd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aq_ifu_btb_upd_ctrl
// Purpose : BTB update/invalidate controller. Looks up the request tag, then
//           installs, refreshes or deletes it, or clears every entry.
// Rev     : 1.0  initial release
// ============================================================================
module aq_ifu_btb_upd_ctrl #(
  parameter int ENTRY_NUM      = 16,
  parameter int BTB_ADDR_WIDTH = 16
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      iu_ifu_btb_upd_vld,
  input  logic                      iu_ifu_btb_upd_del,
  input  logic [BTB_ADDR_WIDTH-1:0] iu_ifu_btb_upd_tag,
  input  logic [BTB_ADDR_WIDTH-1:0] iu_ifu_btb_upd_tgt,
  output logic                      ifu_iu_btb_upd_rdy,
  input  logic                      cp0_ifu_btb_inv,
  output logic                      ifu_cp0_btb_inv_done,
  input  logic [ENTRY_NUM-1:0]      btb_entry_wr_hit_vec,
  output logic [BTB_ADDR_WIDTH-1:0] btb_wr_acc_tag,
  output logic [BTB_ADDR_WIDTH-1:0] btb_upd_tag,
  output logic [BTB_ADDR_WIDTH-1:0] btb_upd_tgt,
  output logic [ENTRY_NUM-1:0]      btb_entry_upd_vec,
  output logic [ENTRY_NUM-1:0]      btb_entry_updg_vec,
  output logic [ENTRY_NUM-1:0]      btb_entry_clr_vec,
  output logic [ENTRY_NUM-1:0]      btb_entry_clrg_vec
);

  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam logic [ENTRY_NUM-1:0] ENT_ONE = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2,
    ST_INV    = 2'd3
  } state_t;

  state_t                    state;
  logic [BTB_ADDR_WIDTH-1:0] req_tag;
  logic [BTB_ADDR_WIDTH-1:0] req_tgt;
  logic                      req_del;
  logic [ENTRY_NUM-1:0]      hit_q;
  logic [PTR_W-1:0]          rr_ptr;

  logic                      miss_install;
  logic [ENTRY_NUM-1:0]      lowest_hit;
  logic [ENTRY_NUM-1:0]      victim_vec;
  logic [ENTRY_NUM-1:0]      upd_vec;
  logic [ENTRY_NUM-1:0]      clr_vec;

  assign miss_install = (hit_q == '0) && !req_del;
  // Two's-complement trick isolates the lowest set bit of the hit vector.
  assign lowest_hit   = hit_q & (~hit_q + ENT_ONE);
  assign victim_vec   = ENT_ONE << rr_ptr;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= ST_IDLE;
      req_tag <= '0;
      req_tgt <= '0;
      req_del <= 1'b0;
      hit_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cp0_ifu_btb_inv) begin
            state <= ST_INV;
          end else if (iu_ifu_btb_upd_vld) begin
            req_tag <= iu_ifu_btb_upd_tag;
            req_tgt <= iu_ifu_btb_upd_tgt;
            req_del <= iu_ifu_btb_upd_del;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_q <= btb_entry_wr_hit_vec;
          state <= cp0_ifu_btb_inv ? ST_INV : ST_WRITE;
        end
        ST_WRITE: begin
          if (cp0_ifu_btb_inv) begin
            state <= ST_INV;
          end else begin
            if (miss_install) rr_ptr <= rr_ptr + PTR_W'(1);
            state <= ST_IDLE;
          end
        end
        ST_INV: begin
          rr_ptr <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A WRITE cycle that collides with an invalidate is dropped entirely.
  always_comb begin
    upd_vec = '0;
    clr_vec = '0;
    if (state == ST_WRITE && !cp0_ifu_btb_inv) begin
      if (hit_q == '0) begin
        if (!req_del) upd_vec = victim_vec;
      end else if (req_del) begin
        clr_vec = hit_q;
      end else begin
        upd_vec = lowest_hit;
        clr_vec = hit_q & ~lowest_hit;
      end
    end else if (state == ST_INV) begin
      clr_vec = '1;
    end
  end

  assign ifu_iu_btb_upd_rdy   = (state == ST_IDLE) && !cp0_ifu_btb_inv;
  assign ifu_cp0_btb_inv_done = (state == ST_INV);
  assign btb_wr_acc_tag       = req_tag;
  assign btb_upd_tag          = req_tag;
  assign btb_upd_tgt          = req_tgt;
  assign btb_entry_upd_vec    = upd_vec;
  assign btb_entry_updg_vec   = upd_vec;
  assign btb_entry_clr_vec    = clr_vec;
  assign btb_entry_clrg_vec   = clr_vec;

endmodule
`default_nettype wire

// File: tb/tb_aq_ifu_btb_upd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_aq_ifu_btb_upd_ctrl
// Purpose : Scoreboard bench for the BTB update controller.
// Rev     : 1.0  initial release
// ============================================================================
module tb_aq_ifu_btb_upd_ctrl;
  localparam int N = 16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         upd_vld = 1'b0;
  logic         upd_del = 1'b0;
  logic [W-1:0] upd_tag_in = '0;
  logic [W-1:0] upd_tgt_in = '0;
  logic         inv = 1'b0;
  logic [N-1:0] hit_vec = '0;
  logic         rdy, inv_done;
  logic [W-1:0] acc_tag, upd_tag, upd_tgt;
  logic [N-1:0] upd, updg, clr, clrg;

  always #5 clk = ~clk;

  aq_ifu_btb_upd_ctrl #(.ENTRY_NUM(N), .BTB_ADDR_WIDTH(W)) dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (rst_n),
    .iu_ifu_btb_upd_vld   (upd_vld),
    .iu_ifu_btb_upd_del   (upd_del),
    .iu_ifu_btb_upd_tag   (upd_tag_in),
    .iu_ifu_btb_upd_tgt   (upd_tgt_in),
    .ifu_iu_btb_upd_rdy   (rdy),
    .cp0_ifu_btb_inv      (inv),
    .ifu_cp0_btb_inv_done (inv_done),
    .btb_entry_wr_hit_vec (hit_vec),
    .btb_wr_acc_tag       (acc_tag),
    .btb_upd_tag          (upd_tag),
    .btb_upd_tgt          (upd_tgt),
    .btb_entry_upd_vec    (upd),
    .btb_entry_updg_vec   (updg),
    .btb_entry_clr_vec    (clr),
    .btb_entry_clrg_vec   (clrg)
  );

  typedef struct {
    logic [N-1:0] upd;
    logic [N-1:0] clr;
    logic         done;
    logic         chk_data;
    logic [W-1:0] tag;
    logic [W-1:0] tgt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ptr_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: victim pointer as an integer, lowest hit found by scan.
  function automatic void model_write(input logic [N-1:0] hit, input logic del,
                                      output logic [N-1:0] u, output logic [N-1:0] c);
    int lo;
    u = '0;
    c = '0;
    lo = 0;
    if (hit == '0) begin
      if (!del) begin
        u[ptr_m] = 1'b1;
        ptr_m = (ptr_m + 1) % N;
      end
    end else if (del) begin
      c = hit;
    end else begin
      for (int i = N - 1; i >= 0; i--) if (hit[i]) lo = i;
      u[lo] = 1'b1;
      c = hit;
      c[lo] = 1'b0;
    end
  endfunction

  function automatic void push_inv();
    q.push_back('{upd: '0, clr: '1, done: 1'b1, chk_data: 1'b0, tag: '0, tgt: '0});
    ptr_m = 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("gate_vecs", {updg, clrg}, {upd, clr});
      if ((|upd) || (|clr) || inv_done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: upd=%0h clr=%0h done=%0b, nothing expected", upd, clr, inv_done);
        end else begin
          mon_e = q.pop_front();
          check("upd_vec", upd, mon_e.upd);
          check("clr_vec", clr, mon_e.clr);
          check("inv_done", inv_done, mon_e.done);
          if (mon_e.chk_data) begin
            check("wr_tag", upd_tag, mon_e.tag);
            check("wr_tgt", upd_tgt, mon_e.tgt);
          end
        end
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  // inv_at: 0 none, 1 invalidate during LOOKUP, 2 invalidate during WRITE.
  task automatic issue_upd(input logic [W-1:0] tag, input logic [W-1:0] tgt,
                           input logic del, input logic [N-1:0] hit, input int inv_at);
    logic [N-1:0] u, c;
    upd_vld = 1'b1; upd_tag_in = tag; upd_tgt_in = tgt; upd_del = del; hit_vec = hit;
    if (inv_at == 0) begin
      model_write(hit, del, u, c);
      if ((|u) || (|c))
        q.push_back('{upd: u, clr: c, done: 1'b0, chk_data: 1'b1, tag: tag, tgt: tgt});
    end else begin
      push_inv();
    end
    @(negedge clk); check("rdy_idle", rdy, 1);
    @(posedge clk); #1; upd_vld = 1'b0; if (inv_at == 1) inv = 1'b1;
    @(negedge clk);
    check("rdy_lookup", rdy, 0);
    check("acc_tag", acc_tag, tag);
    check("upd_tgt_reg", upd_tgt, tgt);
    @(posedge clk); #1; if (inv_at == 1) inv = 1'b0; if (inv_at == 2) inv = 1'b1;
    @(negedge clk); check("rdy_busy", rdy, 0);
    @(posedge clk); #1;
    if (inv_at == 2) begin
      inv = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic inv_with_upd();
    upd_vld = 1'b1; upd_tag_in = 16'h5A5A; upd_del = 1'b0; inv = 1'b1;
    push_inv();
    @(negedge clk); check("rdy_inv_blocked", rdy, 0);
    @(posedge clk); #1; upd_vld = 1'b0; inv = 1'b0;
    @(negedge clk); check("rdy_in_inv", rdy, 0);
    @(posedge clk); #1;
  endtask

  task automatic inv_hold(input int n);
    logic idle;
    idle = 1'b1;
    inv = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (idle) push_inv();
      idle = !idle;
      @(posedge clk); #1;
    end
    inv = 1'b0;
    if (!idle) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [N-1:0] rand_hit();
    logic [31:0] r;
    logic [N-1:0] h;
    r = $urandom();
    h = '0;
    case ($urandom_range(0, 2))
      0: h = '0;
      1: h[$urandom_range(0, N - 1)] = 1'b1;
      default: h = r[N-1:0];
    endcase
    return h;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_done", inv_done, 0);
    check("rst_vecs", {upd, updg, clr, clrg}, 64'h0);
    check("rst_tags", {acc_tag, upd_tag, upd_tgt}, 48'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) issue_upd(16'h1000 + 16'(i), 16'h0100, 1'b0, '0, 0);
    issue_upd(16'h1004, 16'h0100, 1'b0, '0, 0);
    inv_with_upd();
    issue_upd(16'h2000, 16'h0040, 1'b0, '0, 0);
    issue_upd(16'h2000, 16'h0080, 1'b0, 16'h0001, 0);
    issue_upd(16'h2001, 16'h0044, 1'b0, '0, 0);
    inv_hold(1);
    for (int i = 0; i < 17; i++) issue_upd(16'h3000 + 16'(i), 16'h0200, 1'b0, '0, 0);
    issue_upd(16'h4000, 16'h0000, 1'b1, 16'h0020, 0);
    issue_upd(16'h4001, 16'h0000, 1'b1, '0, 0);
    issue_upd(16'h4002, 16'h0000, 1'b1, '0, 0);
    inv_with_upd();
    issue_upd(16'h5000, 16'h0300, 1'b0, '0, 1);
    issue_upd(16'h5001, 16'h0304, 1'b0, 16'h0004, 2);
    issue_upd(16'h6000, 16'h0400, 1'b0, 16'h0090, 0);
    issue_upd(16'h6001, 16'h0404, 1'b1, 16'h0090, 0);
    inv_hold(5);
    issue_upd(16'h7000, 16'h0500, 1'b0, '0, 0);

    upd_vld = 1'b1; upd_tag_in = 16'hBEEF; upd_tgt_in = 16'h1234; upd_del = 1'b0; hit_vec = '0;
    @(posedge clk); #1; upd_vld = 1'b0;
    #2; rst_n = 1'b0; #1;
    check("async_rst_rdy", rdy, 1);
    check("async_rst_tags", {acc_tag, upd_tag, upd_tgt}, 48'h0);
    check("async_rst_out", {upd, clr, inv_done}, 33'h0);
    ptr_m = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    issue_upd(16'h7100, 16'h0600, 1'b0, '0, 0);

    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) inv_with_upd();
      else issue_upd(16'($urandom()), 16'($urandom()), ($urandom_range(0, 3) == 0),
                     rand_hit(), (r == 1) ? $urandom_range(1, 2) : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/aq_ifu_btb_upd_ctrl.md
# aq_ifu_btb_upd_ctrl

Update/invalidate controller for the IFU branch target buffer. It accepts branch-resolution updates from the IU and cache-maintenance invalidates from CP0. For each request it checks whether the tag is already present in the entry array, picks the entry to write (the hit entry or a round-robin victim), and drives the one-hot per-entry update, clear and clock-gate enables into the BTB entry array. It sits directly upstream of the BTB entries and consumes their write-hit outputs.

## Interface
Parameters:
- ENTRY_NUM, 16, number of BTB entries; must be a power of two, minimum 2.
- BTB_ADDR_WIDTH, 16, width of tag and target fields.

Ports:
- forever_cpuclk  in  1  core clock, ungated.
- cpurst_b  in  1  reset, asynchronous, active-low.
- iu_ifu_btb_upd_vld  in  1  update request valid.
- iu_ifu_btb_upd_del  in  1  qualifier on the request: 1 = remove the tag (branch resolved not-taken), 0 = install or refresh.
- iu_ifu_btb_upd_tag  in  BTB_ADDR_WIDTH  branch tag.
- iu_ifu_btb_upd_tgt  in  BTB_ADDR_WIDTH  branch target.
- ifu_iu_btb_upd_rdy  out  1  request accepted when both vld and rdy are high.
- cp0_ifu_btb_inv  in  1  invalidate-all request, level or pulse.
- ifu_cp0_btb_inv_done  out  1  one-cycle pulse when the invalidate completes.
- btb_entry_wr_hit_vec  in  ENTRY_NUM  per-entry write-hit from the entries; combinational on btb_wr_acc_tag.
- btb_wr_acc_tag  out  BTB_ADDR_WIDTH  tag presented to the entries for lookup.
- btb_upd_tag  out  BTB_ADDR_WIDTH  write data, tag.
- btb_upd_tgt  out  BTB_ADDR_WIDTH  write data, target.
- btb_entry_upd_vec, btb_entry_updg_vec  out  ENTRY_NUM  per-entry update and update clock-gate enable.
- btb_entry_clr_vec, btb_entry_clrg_vec  out  ENTRY_NUM  per-entry clear and clear clock-gate enable.

## Operation
- State machine states:
  - IDLE: ifu_iu_btb_upd_rdy = 1 only while cp0_ifu_btb_inv = 0.
  - LOOKUP
  - WRITE
  - INV
- IDLE transitions:
  - If cp0_ifu_btb_inv = 1, go to INV. Invalidate beats a same-cycle update request, and that request is not accepted.
  - Else if iu_ifu_btb_upd_vld = 1, latch tag, target and del into the request register and go to LOOKUP.
- LOOKUP: btb_wr_acc_tag carries the latched tag (it always reflects the request register). Register btb_entry_wr_hit_vec into hit_q, then go to WRITE.
- WRITE: drive one cycle of enables, then return to IDLE.
  - hit_q has exactly one bit set, del = 0: assert upd and updg on that entry.
  - hit_q has exactly one bit set, del = 1: assert clr and clrg on that entry.
  - hit_q has more than one bit set (multi-hit recovery):
    - del = 0: update the lowest-index hit entry; clear every other hit entry.
    - del = 1: clear all hit entries.
  - hit_q = 0, del = 0: update the entry at victim pointer rr_ptr, then rr_ptr <= rr_ptr + 1 modulo ENTRY_NUM (wraps from ENTRY_NUM-1 to 0).
  - hit_q = 0, del = 1: assert no enables; the request completes silently.
  - rr_ptr advances only on a miss-install.
- INV: assert clr and clrg on all entries for one cycle.
  - Pulse ifu_cp0_btb_inv_done in the same cycle.
  - Reset rr_ptr to 0.
  - Return to IDLE.
- Invalidate during LOOKUP or WRITE: the next state is INV. The in-flight request is dropped, and a WRITE cycle that coincides with the invalidate drives no upd enables.
- btb_upd_tag and btb_upd_tgt always carry the request register contents.
- Outside WRITE and INV, every enable vector is all-zero.
- updg and clrg equal upd and clr bit-for-bit in the same cycle, because the entry clock gate needs its enable in the cycle of the write edge.
- Reset values:
  - State IDLE; rdy = 1.
  - All enable vectors 0; inv_done = 0.
  - Request register 0, so btb_wr_acc_tag, btb_upd_tag and btb_upd_tgt are 0.
  - rr_ptr = 0; hit_q = 0.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous). A pending request or invalidate is lost and inv_done is not pulsed.

## Timing
- Update accepted at cycle T (vld & rdy):
  - T+1: LOOKUP; btb_wr_acc_tag holds the new tag.
  - T+2: WRITE; enables asserted.
  - T+3: entry contents updated and visible; rdy high again.
- Throughput: one update per 3 cycles.
- Invalidate seen in IDLE at cycle T: INV at T+1 with clr-all and inv_done; rdy = 1 at T+2.
- Invalidate arriving in LOOKUP or WRITE at cycle T: INV at T+1.
- A level-held cp0_ifu_btb_inv re-enters INV on every IDLE cycle in which it is high.
- Lookup uses hit_q registered at the end of LOOKUP. No other writer touches the entries meanwhile, so there is no read-after-write hazard.

## Test plan
- Reset, then 4 miss-installs, tags 0x1000–0x1003 with del = 0:
  - upd_vec = 0x0001, 0x0002, 0x0004, 0x0008 in successive WRITE cycles, with updg_vec identical.
  - rr_ptr = 4 afterwards.
- Install tag 0x2000 (tgt 0x0040) into entry 0, then update 0x2000 with tgt 0x0080 while the hit vector shows entry 0:
  - upd_vec = 0x0001, btb_upd_tgt = 0x0080.
  - rr_ptr unchanged.
- With ENTRY_NUM = 16, issue 17 misses:
  - The 17th writes upd_vec = 0x0001 (pointer wraps).
- Delete of a hit tag (hit vector 0x0020):
  - clr_vec = clrg_vec = 0x0020 in WRITE.
- Delete of a missing tag:
  - All enable vectors stay 0 and rdy returns at T+3.
- Invalidate scenarios:
  - Assert cp0_ifu_btb_inv at the same cycle as iu_ifu_btb_upd_vld in IDLE: rdy = 0 that cycle; next cycle clr_vec = 0xFFFF with inv_done = 1.
  - Repeat with the invalidate in LOOKUP: no upd enables are ever asserted for the dropped request.
- Multi-hit, hit vector 0x0090, del = 0:
  - upd_vec = 0x0010 and clr_vec = 0x0080 in the same WRITE cycle.
